// File: rtl/abc_operand_loader_pkg.sv
// Shared settings for the A/B/C operand loader: input word width, operand widths, FSM states.
// Operand widths must not exceed IN_W; abc_operand_loader checks this at elaboration.
// Imported by the loader, its interface and the testbench.
package abc_operand_loader_pkg;

  // Width of one serial operand word
  localparam int IN_W   = 8;

  // Operand widths; each operand is the low SIZE_x bits of its input word
  localparam int SIZE_A = 8;
  localparam int SIZE_B = 8;
  localparam int SIZE_C = 8;

  // Loader sequence: three load states followed by the handoff state
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    LOAD_C = 2'd2,
    ISSUE  = 2'd3
  } loader_state_t;

  // Input words are taken in every state except the one that holds a finished triple
  function automatic logic is_load_state(input loader_state_t s);
    return (s != ISSUE);
  endfunction

endpackage

// File: rtl/abc_operand_loader_if.sv
// Operand word stream in (valid/ready) and the {A,B,C} triple out (valid/ready).
// master = upstream/compute side that drives words and out_ready; slave = the loader.
// in_sof exists only when ABC_LOADER_FRAME_EN is defined.
interface abc_operand_loader_if;
  import abc_operand_loader_pkg::*;

  // Serial operand word stream
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
`ifdef ABC_LOADER_FRAME_EN
  logic              in_sof;
`endif

  // Assembled triple towards the compute stage
  logic [SIZE_A-1:0] a_out;
  logic [SIZE_B-1:0] b_out;
  logic [SIZE_C-1:0] c_out;
  logic              out_valid;
  logic              out_ready;

`ifdef ABC_LOADER_FRAME_EN
  modport master (
    output in_data, in_valid, in_sof, out_ready,
    input  in_ready, a_out, b_out, c_out, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_sof, out_ready,
    output in_ready, a_out, b_out, c_out, out_valid
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, a_out, b_out, c_out, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, a_out, b_out, c_out, out_valid
  );
`endif

endinterface

// File: rtl/abc_operand_loader.sv
// Assembles three serial operand words into one {A,B,C} triple and hands it to the compute stage.
// Latency: out_valid rises the cycle after C is accepted; at most one triple per 4 cycles.
// Backpressure: in_ready is low while a triple waits in ISSUE; out_valid holds until out_ready.
// Optional feature macro: ABC_LOADER_FRAME_EN (in_sof resync and sticky frame_err).
module abc_operand_loader
  import abc_operand_loader_pkg::*;
#(
  parameter int IN_W  = abc_operand_loader_pkg::IN_W,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  abc_operand_loader_if.slave    bus,
  output logic [CNT_W-1:0]       issue_cnt,
  output logic                   frame_err
);

  // Operands are sliced out of the input word, so none may be wider than it
  if ((SIZE_A > IN_W) || (SIZE_B > IN_W) || (SIZE_C > IN_W)) begin : g_size_check
    $error("abc_operand_loader: an operand width exceeds IN_W");
  end

  loader_state_t     state;
  logic [SIZE_A-1:0] a_q;
  logic [SIZE_B-1:0] b_q;
  logic [SIZE_C-1:0] c_q;
  logic              valid_q;
  logic              load_rdy;
  logic              accept;

  // Ready depends only on the state, never on in_valid, so there is no comb loop upstream
  assign load_rdy     = is_load_state(state);
  assign accept       = bus.in_valid & load_rdy;

  assign bus.in_ready  = load_rdy;
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.c_out     = c_q;
  assign bus.out_valid = valid_q;

`ifdef ABC_LOADER_FRAME_EN
  logic frame_err_q;
  assign frame_err = frame_err_q;

  // Sequencer with sof resync: an sof word always restarts the triple as A
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      valid_q     <= 1'b0;
      issue_cnt   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (accept) begin
            // A word without sof in LOAD_A means the stream lost alignment; it is still used as A
            if (!bus.in_sof) frame_err_q <= 1'b1;
            a_q   <= bus.in_data[SIZE_A-1:0];
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (bus.in_sof) begin
              a_q         <= bus.in_data[SIZE_A-1:0];
              frame_err_q <= 1'b1;
              state       <= LOAD_B;
            end else begin
              b_q   <= bus.in_data[SIZE_B-1:0];
              state <= LOAD_C;
            end
          end
        end
        LOAD_C: begin
          if (accept) begin
            if (bus.in_sof) begin
              a_q         <= bus.in_data[SIZE_A-1:0];
              frame_err_q <= 1'b1;
              state       <= LOAD_B;
            end else begin
              c_q     <= bus.in_data[SIZE_C-1:0];
              valid_q <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.out_ready) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            valid_q   <= 1'b0;
            state     <= LOAD_A;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= LOAD_A;
        end
      endcase
    end
  end
`else
  assign frame_err = 1'b0;

  // Positional sequencer: words fill A, B, C in order, then the triple waits for out_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD_A;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      valid_q   <= 1'b0;
      issue_cnt <= '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (accept) begin
            a_q   <= bus.in_data[SIZE_A-1:0];
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (accept) begin
            b_q   <= bus.in_data[SIZE_B-1:0];
            state <= LOAD_C;
          end
        end
        LOAD_C: begin
          if (accept) begin
            c_q     <= bus.in_data[SIZE_C-1:0];
            valid_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.out_ready) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            valid_q   <= 1'b0;
            state     <= LOAD_A;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= LOAD_A;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_abc_operand_loader.sv
// Directed-plus-random bench for abc_operand_loader against a word-queue reference model.
// Counter width is reduced so the wrap case stays short.
// Build with ABC_LOADER_FRAME_EN defined to also cover sof resync.
module tb_abc_operand_loader;
  import abc_operand_loader_pkg::*;

  localparam int CW = 8;
  localparam int TW = SIZE_A + SIZE_B + SIZE_C;
  typedef logic [TW-1:0] trip_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] issue_cnt;
  logic          frame_err;

  abc_operand_loader_if bus();

  abc_operand_loader #(.IN_W(IN_W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .issue_cnt (issue_cnt),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  trip_t           obs_q[$];
  trip_t           exp_q[$];
  logic [IN_W-1:0] partial[$];
  int unsigned     exp_cnt;
  bit              exp_ferr;
  bit              rand_ready;

  // Record every handoff the DUT performs
  always @(posedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready)
      obs_q.push_back({bus.a_out, bus.b_out, bus.c_out});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 1) != 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: an sof word (frame mode) restarts the triple; every third word completes one
  task automatic model_accept(input logic [IN_W-1:0] w, input bit sof);
    logic [IN_W-1:0] wa, wb, wc;
`ifdef ABC_LOADER_FRAME_EN
    if (sof) begin
      if (partial.size() != 0) exp_ferr = 1'b1;
      partial.delete();
    end else if (partial.size() == 0) begin
      exp_ferr = 1'b1;
    end
`endif
    partial.push_back(w);
    if (partial.size() == 3) begin
      wa = partial[0];
      wb = partial[1];
      wc = partial[2];
      exp_q.push_back({wa[SIZE_A-1:0], wb[SIZE_B-1:0], wc[SIZE_C-1:0]});
      partial.delete();
    end
  endtask

  task automatic send_word(input logic [IN_W-1:0] w, input bit sof);
    int n = 0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
`ifdef ABC_LOADER_FRAME_EN
    bus.in_sof   = sof;
`endif
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    end else begin
      tick();
      model_accept(w, sof);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_triple(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                             input logic [IN_W-1:0] c);
    send_word(a, 1'b1);
    send_word(b, 1'b0);
    send_word(c, 1'b0);
  endtask

  task automatic expect_triple(input string tag);
    int    n = 0;
    trip_t o, e;
    while (obs_q.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_handoff"}, 32'(obs_q.size() != 0), 32'd1);
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk(tag, 32'(o), 32'(e));
      exp_cnt++;
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset        = 1'b0;
    partial.delete();
    exp_q.delete();
    obs_q.delete();
    exp_cnt  = 0;
    exp_ferr = 1'b0;
  endtask

  initial begin
    logic [IN_W-1:0] r0, r1, r2;
    trip_t           held;

    reset         = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
`ifdef ABC_LOADER_FRAME_EN
    bus.in_sof    = 1'b0;
`endif
    bus.out_ready = 1'b0;
    rand_ready    = 1'b0;
    exp_cnt       = 0;
    exp_ferr      = 1'b0;
    do_reset();

    // Reset state
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_operands", 32'({bus.a_out, bus.b_out, bus.c_out}), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);

    // Basic triple, out_valid right after C is taken
    bus.out_ready = 1'b1;
    send_triple(8'h12, 8'h34, 8'h56);
    chk("t1_valid_latency", 32'(bus.out_valid), 32'd1);
    chk("t1_in_ready_issue", 32'(bus.in_ready), 32'd0);
    chk("t1_abc", 32'({bus.a_out, bus.b_out, bus.c_out}), 32'h123456);
    expect_triple("t1_triple");
    chk("t1_issue_cnt", 32'(issue_cnt), 32'd1);
    chk("t1_valid_dropped", 32'(bus.out_valid), 32'd0);
    chk("t1_operands_kept", 32'({bus.a_out, bus.b_out, bus.c_out}), 32'h123456);

    // Stall in ISSUE for 5 cycles
    bus.out_ready = 1'b0;
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    send_triple(r0, r1, r2);
    held = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_valid_held", 32'(bus.out_valid), 32'd1);
      chk("t2_in_ready_low", 32'(bus.in_ready), 32'd0);
      chk("t2_operands_stable", 32'({bus.a_out, bus.b_out, bus.c_out}), 32'(held));
      chk("t2_cnt_unchanged", 32'(issue_cnt), 32'(exp_cnt));
    end
    bus.out_ready = 1'b1;
    expect_triple("t2_triple");
    chk("t2_issue_cnt", 32'(issue_cnt), 32'd2);

    // Reset mid-triple discards the partial words
    send_word(8'h01, 1'b1);
    send_word(8'h02, 1'b0);
    do_reset();
    chk("t3_rst_a", 32'(bus.a_out), 32'd0);
    send_triple(8'h0A, 8'h0B, 8'h0C);
    expect_triple("t3_triple");
    chk("t3_abc_const", 32'({bus.a_out, bus.b_out, bus.c_out}), 32'h0A0B0C);
    chk("t3_issue_cnt", 32'(issue_cnt), 32'd1);

    // Reset while a triple waits in ISSUE drops it without counting
    bus.out_ready = 1'b0;
    send_triple(8'h77, 8'h88, 8'h99);
    chk("t3b_pending", 32'(bus.out_valid), 32'd1);
    do_reset();
    chk("t3b_valid_dropped", 32'(bus.out_valid), 32'd0);
    chk("t3b_cnt_zero", 32'(issue_cnt), 32'd0);

    // Gapped input with random out_ready: no word lost or duplicated
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send_word(8'($urandom), (i % 3) == 0);
      tick();
    end
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) expect_triple("t5_triple");
    chk("t5_issue_cnt", 32'(issue_cnt), 32'(exp_cnt % (1 << CW)));
    chk("t5_no_extra", 32'(obs_q.size()), 32'd0);
    chk("t5_frame_err", 32'(frame_err), 32'(exp_ferr));

    // Counter wrap
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      send_triple(8'($urandom), 8'($urandom), 8'($urandom));
      expect_triple("t4_triple");
    end
    chk("t4_cnt_max", 32'(issue_cnt), 32'((1 << CW) - 1));
    send_triple(8'($urandom), 8'($urandom), 8'($urandom));
    expect_triple("t4_last");
    chk("t4_cnt_wrap", 32'(issue_cnt), 32'd0);

`ifdef ABC_LOADER_FRAME_EN
    // sof resync in LOAD_C restarts the triple and sets the sticky error
    do_reset();
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b1);
    send_word(8'h44, 1'b0);
    send_word(8'h55, 1'b0);
    expect_triple("t6_triple");
    chk("t6_abc_const", 32'({bus.a_out, bus.b_out, bus.c_out}), 32'h334455);
    chk("t6_frame_err", 32'(frame_err), 32'(exp_ferr));
    send_triple(8'h01, 8'h02, 8'h03);
    expect_triple("t6_after");
    chk("t6_sticky", 32'(frame_err), 32'd1);
    // Missing sof on A sets the error too
    do_reset();
    send_word(8'h5A, 1'b0);
    chk("t6_nosof_err", 32'(frame_err), 32'(exp_ferr));
`else
    chk("frame_err_tied", 32'(frame_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
